// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU and LSU writeback requests onto the single
// register-file write port. It also keeps a scoreboard of the registers that
// outstanding loads have reserved, so the ALU cannot overwrite them out of
// order.
module rf_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  input  logic        lsu_rsv_i,
  input  logic [4:0]  lsu_rsv_addr_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pending_o
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [3:0]  wait_cnt;
  logic        rf_from_lsu;
  logic        alu_elig;
  logic        lsu_elig;
  logic        alu_grant;
  logic        lsu_grant;

  // Eligibility and arbitration: the ALU wins by default, and a starved LSU wins at the limit.
  always_comb begin
    alu_elig  = rst_ni && alu_valid_i &&
                !((alu_addr_i != 5'd0) && pending[alu_addr_i]);
    lsu_elig  = rst_ni && lsu_valid_i;
    lsu_grant = lsu_elig && (!alu_elig || (wait_cnt == WAIT_LIMIT));
    alu_grant = alu_elig && !lsu_grant;
  end

  assign alu_ready_o = alu_grant;
  assign lsu_ready_o = lsu_grant;
  assign pending_o   = pending;

  // Next scoreboard value. The clear is applied first so that a set in the same cycle wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we_o && rf_from_lsu)
      pending_nxt[rf_waddr_o] = 1'b0;
    if (lsu_rsv_i)
      pending_nxt[lsu_rsv_addr_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pending <= '0;
    else         pending <= pending_nxt;
  end

  // Starvation counter: counts refused LSU cycles, saturating, and clears on an LSU grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      wait_cnt <= '0;
    else if (lsu_grant)
      wait_cnt <= '0;
    else if (lsu_valid_i && (wait_cnt != WAIT_LIMIT))
      wait_cnt <= wait_cnt + 4'd1;
  end

  // Registered write port. A grant to x0 consumes the request but writes nothing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_we_o     <= 1'b0;
      rf_waddr_o  <= '0;
      rf_wdata_o  <= '0;
      rf_from_lsu <= 1'b0;
    end else if (lsu_grant) begin
      rf_we_o     <= (lsu_addr_i != 5'd0);
      rf_waddr_o  <= lsu_addr_i;
      rf_wdata_o  <= lsu_data_i;
      rf_from_lsu <= 1'b1;
    end else if (alu_grant) begin
      rf_we_o     <= (alu_addr_i != 5'd0);
      rf_waddr_o  <= alu_addr_i;
      rf_wdata_o  <= alu_data_i;
      rf_from_lsu <= 1'b0;
    end else begin
      rf_we_o     <= 1'b0;
      rf_from_lsu <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter. A table of per-cycle vectors holds the inputs
// and the expected readies and pending bits. Each expected write-port result
// is pushed to a queue and then compared one cycle later.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, lsu_rsv;
  logic [4:0]  alu_addr, lsu_addr, lsu_rsv_addr;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_ready_o(lsu_ready),
    .lsu_rsv_i(lsu_rsv), .lsu_rsv_addr_i(lsu_rsv_addr),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pending_o(pending)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rv;
    logic [4:0]  ra;
    logic        ar;
    logic        lr;
    logic [31:0] pend;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        known;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cur = -1;

  task automatic add(input logic rst, input logic av, input logic [4:0] aa,
                     input logic [31:0] ad, input logic lv, input logic [4:0] la,
                     input logic [31:0] ld, input logic rv, input logic [4:0] ra,
                     input logic ar, input logic lr, input logic [31:0] pend);
    vec_t v;
    v = '{rst, av, aa, ad, lv, la, ld, rv, ra, ar, lr, pend};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
  endtask

  initial begin
    exp_t        e, nx;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic        known;

    // Columns: rst av aa ad lv la ld rv ra | ar lr pend
    // single ALU write
    add(1, 1,  5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 1, 0, 32'h0);   // 0
    add(1, 0,  0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0);   // 1
    add(1, 0,  0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0);   // 2
    // contention: ALU x3, LSU, ALU x3, LSU
    add(1, 1, 10, 32'hA000_0001, 1, 2, 32'h1111_0001, 0, 0, 1, 0, 32'h0); // 3
    add(1, 1, 11, 32'hA000_0002, 1, 2, 32'h1111_0001, 0, 0, 1, 0, 32'h0); // 4
    add(1, 1, 12, 32'hA000_0003, 1, 2, 32'h1111_0001, 0, 0, 1, 0, 32'h0); // 5
    add(1, 1, 13, 32'hA000_0004, 1, 2, 32'h1111_0001, 0, 0, 0, 1, 32'h0); // 6
    add(1, 1, 13, 32'hA000_0004, 1, 3, 32'h2222_0002, 0, 0, 1, 0, 32'h0); // 7
    add(1, 1, 14, 32'hA000_0005, 1, 3, 32'h2222_0002, 0, 0, 1, 0, 32'h0); // 8
    add(1, 1, 15, 32'hA000_0006, 1, 3, 32'h2222_0002, 0, 0, 1, 0, 32'h0); // 9
    add(1, 1, 16, 32'hA000_0007, 1, 3, 32'h2222_0002, 0, 0, 0, 1, 32'h0); // 10
    // x0 write
    add(1, 1,  0, 32'h0000_1234, 0, 0, 0,            0, 0, 1, 0, 32'h0);  // 11
    // WAW guard on x7
    add(1, 0,  0, 0,            0, 0, 0,            1, 7, 0, 0, 32'h0);   // 12
    add(1, 1,  7, 32'hA7A7_A7A7, 0, 0, 0,           0, 0, 0, 0, 32'h80);  // 13
    add(1, 1,  7, 32'hA7A7_A7A7, 1, 7, 32'h7777_7777, 0, 0, 0, 1, 32'h80);// 14
    add(1, 1,  7, 32'hA7A7_A7A7, 0, 0, 0,           0, 0, 0, 0, 32'h80);  // 15
    add(1, 1,  7, 32'hA7A7_A7A7, 0, 0, 0,           0, 0, 1, 0, 32'h0);   // 16
    add(1, 0,  0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0);   // 17
    // simultaneous set/clear on x9, then an ignored x0 reservation
    add(1, 0,  0, 0,            0, 0, 0,            1, 9, 0, 0, 32'h0);   // 18
    add(1, 0,  0, 0,            1, 9, 32'h9999_9999, 0, 0, 0, 1, 32'h200);// 19
    add(1, 0,  0, 0,            0, 0, 0,            1, 9, 0, 0, 32'h200); // 20
    add(1, 0,  0, 0,            0, 0, 0,            1, 0, 0, 0, 32'h200); // 21
    // reset mid-operation with an ALU request to x3
    add(0, 1,  3, 32'h3333_3333, 1, 4, 32'h4444_4444, 0, 0, 0, 0, 32'h200);// 22
    add(1, 0,  0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0);   // 23
    add(1, 0,  0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0);   // 24

    rst_n = 1'b0; alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0; lsu_rsv = 0; lsu_rsv_addr = 0;
    @(posedge clk);
    @(posedge clk);
    e = '{1'b0, 5'd0, 32'd0, 1'b1};
    exp_q.push_back(e);
    last_addr = 5'd0; last_data = 32'd0; known = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      cur = i;
      @(negedge clk);
      rst_n = v.rst; alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
      lsu_valid = v.lv; lsu_addr = v.la; lsu_data = v.ld;
      lsu_rsv = v.rv; lsu_rsv_addr = v.ra;
      #1;
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, v.ar});
      chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, v.lr});
      chk("pending", pending, v.pend);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard_empty (vector %0d): got empty queue, expected an entry", i);
      end else begin
        e = exp_q.pop_front();
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        if (e.known) begin
          chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
      // expected write port contents after this cycle's edge
      if (!v.rst) begin
        nx = '{1'b0, 5'd0, 32'd0, 1'b1};
      end else if (v.ar) begin
        nx = '{(v.aa != 5'd0), v.aa, v.ad, (v.aa != 5'd0)};
      end else if (v.lr) begin
        nx = '{(v.la != 5'd0), v.la, v.ld, (v.la != 5'd0)};
      end else begin
        nx = '{1'b0, last_addr, last_data, known};
      end
      last_addr = nx.addr; last_data = nx.data; known = nx.known;
      exp_q.push_back(nx);
    end

    @(negedge clk);
    #1;
    cur = tbl.size();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rf_we_final", {31'd0, rf_we}, {31'd0, e.we});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
